// File: rtl/mvu_dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mvu_dma_pkg                                                      |
// | Purpose : Definitions shared by the MVU inbound (load) and readback DMAs:  |
// |           FSM state encoding, status-word bit positions and the default    |
// |           MVU RAM geometry.                                                |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mvu_dma_pkg;

  // Default MVU data RAM geometry. Both DMAs use the same values.
  localparam int MVU_AW_DEF = 15;
  localparam int MVU_DW_DEF = 64;

  // Dense binary state encoding in 3 bits.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_HI   = 3'd3,
    S_WR_LO   = 3'd4,
    S_DONE    = 3'd5
  } dma_state_e;

  // Layout of the 32-bit status word.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_REM_LSB  = 16;
  localparam int STAT_REM_W    = 16;

endpackage : mvu_dma_pkg
`default_nettype wire

// File: rtl/mvu_dma_irq_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mvu_dma_irq_pulse                                                |
// | Purpose : Registered one-cycle pulse generator for DMA completion          |
// |           interrupts. A rising edge on trig_i gives one high cycle on      |
// |           pulse_o, one clock later.                                        |
// | Ports   : clk, rst_n   clock and asynchronous active-low reset             |
// |           trig_i       completion event (may be held high)                 |
// |           pulse_o      registered single-cycle pulse                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mvu_dma_irq_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  output logic pulse_o
);

  logic trig_q;
  logic pulse_q;

  // Edge detection: a trigger held high still produces only one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      trig_q  <= trig_i;
      pulse_q <= trig_i & ~trig_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule : mvu_dma_irq_pulse
`default_nettype wire

// File: rtl/mvu_result_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mvu_result_dma                                                   |
// | Purpose : Readback DMA. Moves 64-bit MVU data RAM words into 32-bit system |
// |           memory. Each word becomes two system writes, high half first.   |
// |           This is the inverse of the inbound packing, so a load followed   |
// |           by a readback returns the data unchanged.                        |
// | Ports   : mvu_rd_*        MVU RAM read request / response                  |
// |           sys_wr_*        system memory write channel                      |
// |           dma_*_i         transfer configuration and start pulse          |
// |           dma_status_o    [0] busy, [1] done (sticky), [31:16] remaining   |
// |           dma_irq         one-cycle completion pulse                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mvu_result_dma
  import mvu_dma_pkg::*;
#(
  parameter int MVU_AW = MVU_AW_DEF,
  parameter int MVU_DW = MVU_DW_DEF,
  parameter int SYS_AW = 32,
  parameter int SYS_DW = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // MVU data RAM read port
  output logic [MVU_AW-1:0] mvu_rd_addr,
  output logic              mvu_rd_valid,
  input  logic              mvu_rd_ready,
  input  logic [MVU_DW-1:0] mvu_rd_rsp_data,
  input  logic              mvu_rd_rsp_valid,
  // System write port
  output logic [SYS_AW-1:0] sys_wr_addr,
  output logic [SYS_DW-1:0] sys_wr_data,
  output logic              sys_wr_valid,
  input  logic              sys_wr_ready,
  // Register block interface
  input  logic [MVU_AW-1:0] dma_src_addr_i,
  input  logic [SYS_AW-1:0] dma_dest_addr_i,
  input  logic [CNT_W-1:0]  dma_transfer_size_i,
  input  logic              dma_transfer_start_i,
  output logic [31:0]       dma_status_o,
  output logic              dma_irq
);

  dma_state_e        state_q;
  logic [MVU_AW-1:0] src_ptr_q;
  logic [SYS_AW-1:0] dst_ptr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [MVU_DW-1:0] hold_q;
  logic              done_q;
  logic              irq_set_d;

  // The next state is DONE. The pulse generator adds one register stage,
  // so dma_irq is high exactly while the FSM is in DONE.
  assign irq_set_d =
      ((state_q == S_IDLE) && dma_transfer_start_i && (dma_transfer_size_i == '0)) ||
      ((state_q == S_WR_LO) && sys_wr_ready && (remaining_q == CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dma_transfer_start_i) begin
            src_ptr_q   <= dma_src_addr_i;
            dst_ptr_q   <= dma_dest_addr_i;
            remaining_q <= dma_transfer_size_i;
            done_q      <= 1'b0;
            state_q     <= (dma_transfer_size_i != '0) ? S_RD_REQ : S_DONE;
          end
        end
        S_RD_REQ: begin
          if (mvu_rd_ready) begin
            src_ptr_q <= src_ptr_q + MVU_AW'(1);
            state_q   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // Responses are only taken here. Any stray response in another
          // state does not change the hold register.
          if (mvu_rd_rsp_valid) begin
            hold_q  <= mvu_rd_rsp_data;
            state_q <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          if (sys_wr_ready) begin
            dst_ptr_q <= dst_ptr_q + SYS_AW'(1);
            state_q   <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (sys_wr_ready) begin
            dst_ptr_q   <= dst_ptr_q + SYS_AW'(1);
            remaining_q <= remaining_q - CNT_W'(1);
            // remaining_q is never 0 here, so the decrement cannot underflow.
            state_q     <= (remaining_q == CNT_W'(1)) ? S_DONE : S_RD_REQ;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every bus output depends only on registers. There is no path from a
  // ready input to a valid output, and address/data stay stable while a
  // request waits.
  assign mvu_rd_valid = (state_q == S_RD_REQ);
  assign mvu_rd_addr  = src_ptr_q;
  assign sys_wr_valid = (state_q == S_WR_HI) || (state_q == S_WR_LO);
  assign sys_wr_addr  = dst_ptr_q;
  assign sys_wr_data  = (state_q == S_WR_HI) ? hold_q[MVU_DW-1:SYS_DW]
                                             : hold_q[SYS_DW-1:0];

  always_comb begin
    dma_status_o                              = '0;
    dma_status_o[STAT_BUSY_BIT]               = (state_q != S_IDLE);
    dma_status_o[STAT_DONE_BIT]               = done_q;
    dma_status_o[STAT_REM_LSB +: STAT_REM_W]  = STAT_REM_W'(remaining_q);
  end

  mvu_dma_irq_pulse u_irq_pulse (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig_i  (irq_set_d),
    .pulse_o (dma_irq)
  );

endmodule : mvu_result_dma
`default_nettype wire

// File: tb/tb_mvu_result_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mvu_result_dma                                                |
// | Purpose : Directed self-checking bench for mvu_result_dma. Background      |
// |           processes drive the ready signals and return MVU read data.      |
// |           Each test task drives its own stimulus and compares the results  |
// |           against hand-computed values.                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mvu_result_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] mvu_rd_addr;
  logic        mvu_rd_valid, mvu_rd_ready;
  logic [63:0] mvu_rd_rsp_data;
  logic        mvu_rd_rsp_valid;
  logic [31:0] sys_wr_addr, sys_wr_data;
  logic        sys_wr_valid, sys_wr_ready;
  logic [14:0] dma_src_addr_i;
  logic [31:0] dma_dest_addr_i;
  logic [15:0] dma_transfer_size_i;
  logic        dma_transfer_start_i;
  logic [31:0] dma_status_o;
  logic        dma_irq;

  int errors = 0;
  int checks = 0;
  int rd_mode = 0;    // 0 ready always, 1 random, 2 held low
  int wr_mode = 0;
  int rsp_dmax = 0;   // extra response delay, cycles (0 = exactly 1 cycle)
  int irq_cnt = 0;
  logic [14:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  always #5 clk = ~clk;

  mvu_result_dma dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .mvu_rd_addr          (mvu_rd_addr),
    .mvu_rd_valid         (mvu_rd_valid),
    .mvu_rd_ready         (mvu_rd_ready),
    .mvu_rd_rsp_data      (mvu_rd_rsp_data),
    .mvu_rd_rsp_valid     (mvu_rd_rsp_valid),
    .sys_wr_addr          (sys_wr_addr),
    .sys_wr_data          (sys_wr_data),
    .sys_wr_valid         (sys_wr_valid),
    .sys_wr_ready         (sys_wr_ready),
    .dma_src_addr_i       (dma_src_addr_i),
    .dma_dest_addr_i      (dma_dest_addr_i),
    .dma_transfer_size_i  (dma_transfer_size_i),
    .dma_transfer_start_i (dma_transfer_start_i),
    .dma_status_o         (dma_status_o),
    .dma_irq              (dma_irq)
  );

  // Contents of the MVU RAM as the bench defines them.
  function automatic logic [63:0] word_of(input logic [14:0] a);
    if (a == 15'h010) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {16'hD000, 1'b0, a, 16'h5A00, 1'b0, a};
  endfunction

  initial begin
    mvu_rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rd_mode)
        0:       mvu_rd_ready = 1'b1;
        1:       mvu_rd_ready = ($urandom_range(0, 2) == 0);
        default: mvu_rd_ready = 1'b0;
      endcase
    end
  end

  initial begin
    sys_wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        0:       sys_wr_ready = 1'b1;
        1:       sys_wr_ready = ($urandom_range(0, 2) == 0);
        default: sys_wr_ready = 1'b0;
      endcase
    end
  end

  // MVU RAM responder: returns the data 1 + (0..rsp_dmax) cycles after accept.
  initial begin
    logic [14:0] a;
    int d;
    mvu_rd_rsp_valid = 1'b0;
    mvu_rd_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mvu_rd_valid && mvu_rd_ready) begin
        a = mvu_rd_addr;
        d = (rsp_dmax == 0) ? 0 : $urandom_range(0, rsp_dmax);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 mvu_rd_rsp_valid = 1'b1;
        mvu_rd_rsp_data = word_of(a);
        @(posedge clk);
        #1 mvu_rd_rsp_valid = 1'b0;
        mvu_rd_rsp_data = 64'h0BAD_0BAD_0BAD_0BAD;
      end
    end
  end

  // Handshake logger. A handshake seen at the negedge completes on the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mvu_rd_valid && mvu_rd_ready) rd_log.push_back(mvu_rd_addr);
        if (sys_wr_valid && sys_wr_ready) begin
          wa_log.push_back(sys_wr_addr);
          wd_log.push_back(sys_wr_data);
        end
        if (dma_irq) irq_cnt++;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  task automatic do_start(input logic [14:0] src, input logic [31:0] dst, input logic [15:0] size);
    @(posedge clk); #1;
    dma_src_addr_i       = src;
    dma_dest_addr_i      = dst;
    dma_transfer_size_i  = size;
    dma_transfer_start_i = 1'b1;
    @(posedge clk); #1;
    dma_transfer_start_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mvu_rd_valid, sys_wr_valid, dma_irq} !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got %b want 000", {mvu_rd_valid, sys_wr_valid, dma_irq});
    end
    checks++;
    if ({mvu_rd_addr, sys_wr_addr, sys_wr_data} !== '0) begin
      errors++; $display("FAIL reset_addr_data: got %h %h %h want 0", mvu_rd_addr, sys_wr_addr, sys_wr_data);
    end
    checks++;
    if (dma_status_o !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h want 00000000", dma_status_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit got;
    int c0;
    rd_mode = 0; wr_mode = 0; rsp_dmax = 0;
    clear_logs(); c0 = irq_cnt;
    do_start(15'h010, 32'h0000_1000, 16'd1);
    @(negedge clk);
    checks++;
    if (mvu_rd_valid !== 1'b1 || mvu_rd_addr !== 15'h010) begin
      errors++; $display("FAIL single_rd_latency: valid=%b addr=%h want 1 010", mvu_rd_valid, mvu_rd_addr);
    end
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); if (dma_irq) got = 1; end
    checks++;
    if (!got || dma_status_o[0] !== 1'b1) begin
      errors++; $display("FAIL single_irq_busy: irq_seen=%0d busy=%b want 1 1", got, dma_status_o[0]);
    end
    @(negedge clk);
    checks++;
    if (dma_irq !== 1'b0 || dma_status_o !== 32'h0000_0002) begin
      errors++; $display("FAIL single_status_after: irq=%b status=%h want 0 00000002", dma_irq, dma_status_o);
    end
    checks++;
    if (wa_log.size() != 2 || wa_log[0] !== 32'h1000 || wd_log[0] !== 32'hAAAA_BBBB ||
        wa_log[1] !== 32'h1001 || wd_log[1] !== 32'hCCCC_DDDD) begin
      errors++; $display("FAIL single_writes: n=%0d want 2 (AAAABBBB@1000, CCCCDDDD@1001)", wa_log.size());
    end
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 15'h010 || irq_cnt - c0 != 1) begin
      errors++; $display("FAIL single_reads_irq: reads=%0d irqs=%0d want 1 1", rd_log.size(), irq_cnt - c0);
    end
  endtask

  task automatic test_random();
    bit got;
    int prev;
    int seq[$];
    logic [63:0] w;
    logic [31:0] ed;
    rd_mode = 1; wr_mode = 1; rsp_dmax = 5;
    clear_logs();
    do_start(15'h100, 32'h0000_2000, 16'd3);
    got = 0; prev = -1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (int'(dma_status_o[31:16]) != prev) begin
        prev = int'(dma_status_o[31:16]);
        seq.push_back(prev);
      end
      if (dma_irq) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL random_irq_timeout: irq=0 want 1"); end
    checks++;
    if (seq.size() != 4 || seq[0] != 3 || seq[1] != 2 || seq[2] != 1 || seq[3] != 0) begin
      errors++; $display("FAIL random_remaining_seq: n=%0d want 3,2,1,0", seq.size());
    end
    for (int i = 0; i < 6; i++) begin
      w  = word_of(15'h100 + 15'(i / 2));
      ed = (i % 2 == 0) ? w[63:32] : w[31:0];
      checks++;
      if (i >= wa_log.size() || wa_log[i] !== 32'h2000 + 32'(i) || wd_log[i] !== ed) begin
        errors++; $display("FAIL random_write%0d: n=%0d want %h@%h", i, wa_log.size(), ed, 32'h2000 + 32'(i));
      end
    end
    checks++;
    if (rd_log.size() != 3 || rd_log[0] !== 15'h100 || rd_log[1] !== 15'h101 || rd_log[2] !== 15'h102) begin
      errors++; $display("FAIL random_reads: n=%0d want 100,101,102", rd_log.size());
    end
    rd_mode = 0; wr_mode = 0; rsp_dmax = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_zero();
    int vseen;
    clear_logs();
    vseen = 0;
    do_start(15'h0AA, 32'h0000_0AAA, 16'd0);
    @(negedge clk);
    checks++;
    if (dma_irq !== 1'b1 || dma_status_o[0] !== 1'b1) begin
      errors++; $display("FAIL zero_irq_latency: irq=%b busy=%b want 1 1", dma_irq, dma_status_o[0]);
    end
    for (int i = 0; i < 5; i++) begin
      if (mvu_rd_valid || sys_wr_valid) vseen++;
      @(negedge clk);
    end
    checks++;
    if (vseen != 0 || rd_log.size() != 0 || wa_log.size() != 0) begin
      errors++; $display("FAIL zero_no_bus: valid_cycles=%0d reads=%0d writes=%0d want 0", vseen, rd_log.size(), wa_log.size());
    end
    checks++;
    if (dma_status_o !== 32'h0000_0002) begin
      errors++; $display("FAIL zero_status: got %h want 00000002", dma_status_o);
    end
  endtask

  task automatic test_stall();
    bit got;
    int bad;
    int c0;
    logic [63:0] w0, w1;
    clear_logs(); c0 = irq_cnt;
    wr_mode = 2;
    w0 = word_of(15'h020); w1 = word_of(15'h021);
    do_start(15'h020, 32'h0000_3000, 16'd2);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); if (sys_wr_valid) got = 1; end
    checks++;
    if (!got) begin errors++; $display("FAIL stall_no_wr_valid: valid=0 want 1"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      dma_transfer_start_i = ~i[0];
      dma_src_addr_i       = 15'h555;
      dma_dest_addr_i      = 32'h0000_9999;
      dma_transfer_size_i  = 16'd7;
      @(negedge clk);
      if (sys_wr_valid !== 1'b1 || sys_wr_addr !== 32'h3000 || sys_wr_data !== w0[63:32]) bad++;
    end
    dma_transfer_start_i = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_stable: unstable_cycles=%0d addr=%h data=%h want 0 %h %h",
                         bad, sys_wr_addr, sys_wr_data, 32'h3000, w0[63:32]);
    end
    wr_mode = 0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); if (dma_irq) got = 1; end
    repeat (4) @(negedge clk);
    checks++;
    if (!got || wa_log.size() != 4 || wd_log[0] !== w0[63:32] || wd_log[1] !== w0[31:0] ||
        wd_log[2] !== w1[63:32] || wd_log[3] !== w1[31:0] || wa_log[3] !== 32'h3003) begin
      errors++; $display("FAIL stall_writes: irq=%0d n=%0d want 1 4 (dst 3000..3003)", got, wa_log.size());
    end
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 15'h020 || rd_log[1] !== 15'h021 || irq_cnt - c0 != 1) begin
      errors++; $display("FAIL stall_starts_ignored: reads=%0d irqs=%0d want 2 1", rd_log.size(), irq_cnt - c0);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [63:0] w;
    clear_logs();
    do_start(15'h040, 32'h0000_4000, 16'd4);
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); if (wa_log.size() == 3) got = 1; end
    @(posedge clk); #1;
    checks++;
    if (!got || sys_wr_valid !== 1'b1 || sys_wr_addr !== 32'h4003 || dma_status_o[31:16] !== 16'd3) begin
      errors++; $display("FAIL rstmid_in_wr_lo: seen=%0d valid=%b addr=%h rem=%0d want 1 1 4003 3",
                         got, sys_wr_valid, sys_wr_addr, dma_status_o[31:16]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mvu_rd_valid, sys_wr_valid, dma_irq} !== 3'b000 || mvu_rd_addr !== '0 ||
        sys_wr_addr !== '0 || sys_wr_data !== '0 || dma_status_o !== '0) begin
      errors++; $display("FAIL rstmid_outputs: valids=%b addr=%h/%h data=%h status=%h want all 0",
                         {mvu_rd_valid, sys_wr_valid, dma_irq}, mvu_rd_addr, sys_wr_addr, sys_wr_data, dma_status_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    w = word_of(15'h060);
    do_start(15'h060, 32'h0000_5000, 16'd1);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); if (dma_irq) got = 1; end
    checks++;
    if (!got || rd_log.size() != 1 || rd_log[0] !== 15'h060 || wa_log.size() != 2 ||
        wa_log[0] !== 32'h5000 || wd_log[0] !== w[63:32] || wa_log[1] !== 32'h5001 || wd_log[1] !== w[31:0]) begin
      errors++; $display("FAIL rstmid_restart: irq=%0d reads=%0d writes=%0d want 1 1 2 (at 5000)", got, rd_log.size(), wa_log.size());
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit got;
    logic [63:0] w;
    clear_logs();
    w = word_of(15'h7FFF);
    do_start(15'h7FFF, 32'hFFFF_FFFF, 16'd1);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); if (dma_irq) got = 1; end
    checks++;
    if (!got || rd_log.size() != 1 || rd_log[0] !== 15'h7FFF) begin
      errors++; $display("FAIL wrap_read: irq=%0d reads=%0d want 1 1 at 7fff", got, rd_log.size());
    end
    checks++;
    if (wa_log.size() != 2 || wa_log[0] !== 32'hFFFF_FFFF || wa_log[1] !== 32'h0000_0000 ||
        wd_log[0] !== w[63:32] || wd_log[1] !== w[31:0]) begin
      errors++; $display("FAIL wrap_writes: n=%0d want 2 at ffffffff then 00000000", wa_log.size());
    end
  endtask

  initial begin
    rst_n                = 1'b0;
    dma_src_addr_i       = '0;
    dma_dest_addr_i      = '0;
    dma_transfer_size_i  = '0;
    dma_transfer_start_i = 1'b0;
    test_reset();
    test_single();
    test_random();
    test_zero();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mvu_result_dma
`default_nettype wire
